// File: rtl/mem_fill_engine.sv
// mem_fill_engine
// Memory initialiser and built-in self-test for the S-array RAM. On start it
// sweeps addresses 0..DEPTH-1 writing a pattern (identity, constant or
// reverse). It can then read every location back and count mismatches.
//
// Ports:
//   clk            clock, all logic rising-edge
//   reset_n        asynchronous active-low reset
//   start          level request, held high for the whole run; low aborts
//   mode           00 identity, 01 constant, 10 reverse, 11 identity
//   verify         1 = read-back pass after the write pass
//   fill_value     constant used by mode 01
//   q              RAM read data, valid RD_LAT edges after the address
//   address        RAM address
//   data           RAM write data
//   wren           RAM write enable
//   busy           high in WRITE, READ and DRAIN
//   done           high in DONE
//   err_count      saturating mismatch count of the last verify pass
//   first_err_addr address of the first mismatch of the run, 0 if none
module mem_fill_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              verify,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  // One extra counter bit so DEPTH = 2^ADDR_W never wraps.
  localparam int               CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  ERR_MAX = '1;
  localparam logic [1:0]       DR_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic [1:0]        r_drain, w_drain_nx;
  logic [DATA_W-1:0] r_data, w_data_nx;
  logic              r_wren, w_wren_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic              w_latch, w_issue, w_flush;
  logic [DATA_W-1:0] w_exp;

  logic [1:0]        r_mode;
  logic              r_verify;
  logic [DATA_W-1:0] r_fill;

  // Compare pipeline: expected value and address ride alongside the read.
  logic              r_pv    [RD_LAT];
  logic [DATA_W-1:0] r_pexp  [RD_LAT];
  logic [ADDR_W-1:0] r_paddr [RD_LAT];

  logic [ADDR_W:0]   r_err_count;
  logic [ADDR_W-1:0] r_first_err;
  logic              r_err_seen;
  logic              w_mismatch;

  // Pattern value for a given address; truncated to DATA_W bits.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [CNT_W-1:0]  a,
    input logic [DATA_W-1:0] fv
  );
    logic [CNT_W-1:0] rev;
    rev = LAST - a;
    case (m)
      2'b01:   pattern = fv;
      2'b10:   pattern = DATA_W'(rev);
      default: pattern = DATA_W'(a);
    endcase
  endfunction

  // Next-state and next-output logic of the sweep FSM.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_drain_nx = r_drain;
    w_data_nx  = r_data;
    w_wren_nx  = 1'b0;
    w_busy_nx  = 1'b0;
    w_done_nx  = 1'b0;
    w_latch    = 1'b0;
    w_issue    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          // Configuration is taken straight from the pins on this edge.
          w_latch    = 1'b1;
          w_state_nx = S_WRITE;
          w_cnt_nx   = '0;
          w_data_nx  = pattern(mode, CNT_W'(0), fill_value);
          w_wren_nx  = 1'b1;
          w_busy_nx  = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_WRITE: begin
        if (!start) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == LAST) begin
          w_cnt_nx = '0;
          if (r_verify) begin
            // Zero-cycle turnaround: the read of address 0 issues now.
            w_state_nx = S_READ;
            w_issue    = 1'b1;
            w_busy_nx  = 1'b1;
          end else begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end
        end else begin
          w_cnt_nx  = r_cnt + CNT_W'(1);
          w_data_nx = pattern(r_mode, r_cnt + CNT_W'(1), r_fill);
          w_wren_nx = 1'b1;
          w_busy_nx = 1'b1;
        end
      end
      S_READ: begin
        if (!start) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == LAST) begin
          w_state_nx = S_DRAIN;
          w_drain_nx = 2'd0;
          w_busy_nx  = 1'b1;
        end else begin
          w_cnt_nx  = r_cnt + CNT_W'(1);
          w_issue   = 1'b1;
          w_busy_nx = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!start) begin
          w_state_nx = S_IDLE;
        end else if (r_drain == DR_LAST) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end else begin
          w_drain_nx = r_drain + 2'd1;
          w_busy_nx  = 1'b1;
        end
      end
      S_DONE: begin
        if (!start) begin
          w_state_nx = S_IDLE;
        end else begin
          w_done_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign w_exp   = pattern(r_mode, w_cnt_nx, r_fill);
  // Any return to IDLE (abort or handshake end) discards outstanding reads.
  assign w_flush = (w_state_nx == S_IDLE);

  // FSM state, sweep counter and registered RAM-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_drain  <= 2'd0;
      r_data   <= '0;
      r_wren   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mode   <= 2'b00;
      r_verify <= 1'b0;
      r_fill   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_drain <= w_drain_nx;
      r_data  <= w_data_nx;
      r_wren  <= w_wren_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      if (w_latch) begin
        r_mode   <= mode;
        r_verify <= verify;
        r_fill   <= fill_value;
      end
    end
  end

  // Read compare pipeline; stage RD_LAT-1 is due on the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i]    <= 1'b0;
        r_pexp[i]  <= '0;
        r_paddr[i] <= '0;
      end
    end else if (w_flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
      end
    end else begin
      r_pv[0]    <= w_issue;
      r_pexp[0]  <= w_exp;
      r_paddr[0] <= w_cnt_nx[ADDR_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_pexp[i]  <= r_pexp[i-1];
        r_paddr[i] <= r_paddr[i-1];
      end
    end
  end

  assign w_mismatch = r_pv[RD_LAT-1] && (q != r_pexp[RD_LAT-1]);

  // Mismatch counter and first-failing-address capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
      r_first_err <= '0;
      r_err_seen  <= 1'b0;
    end else if (w_latch) begin
      r_err_count <= '0;
      r_first_err <= '0;
      r_err_seen  <= 1'b0;
    end else if (w_mismatch) begin
      if (r_err_count != ERR_MAX) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
      if (!r_err_seen) begin
        r_first_err <= r_paddr[RD_LAT-1];
        r_err_seen  <= 1'b1;
      end
    end
  end

  assign address        = r_cnt[ADDR_W-1:0];
  assign data           = r_data;
  assign wren           = r_wren;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err;

endmodule

// File: tb/tb_mem_fill_engine.sv
// Testbench for mem_fill_engine: a 256-entry instance with a zero-wait RAM
// model (RD_LAT=1) and a 16-entry instance with a one-register RAM model
// (RD_LAT=2). Expected writes and run results are queued when a run is
// launched and popped as the DUT produces them.
module tb_mem_fill_engine;

  localparam int DP  = 256;
  localparam int RL  = 1;
  localparam int DP2 = 16;
  localparam int RL2 = 2;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int err;
    int first;
    int dcyc;
  } res_t;

  logic clk;
  logic reset_n;

  // 256-entry instance
  logic       start, verify, wren, busy, done;
  logic [1:0] mode;
  logic [7:0] fill_value, q, address, data, first_err_addr;
  logic [8:0] err_count;

  // 16-entry instance
  logic       start2, verify2, wren2, busy2, done2;
  logic [1:0] mode2;
  logic [7:0] fill2, q2, q2_c, data2;
  logic [3:0] address2, first2;
  logic [4:0] err2;

  logic [7:0] mem  [DP];
  logic [7:0] mem2 [DP2];
  logic       inj, inj2;

  wr_t  wq[$];
  res_t rq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   found;

  mem_fill_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(DP), .RD_LAT(RL)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .verify(verify),
    .fill_value(fill_value), .q(q), .address(address), .data(data), .wren(wren),
    .busy(busy), .done(done), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  mem_fill_engine #(.ADDR_W(4), .DATA_W(8), .DEPTH(DP2), .RD_LAT(RL2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .mode(mode2), .verify(verify2),
    .fill_value(fill2), .q(q2), .address(address2), .data(data2), .wren(wren2),
    .busy(busy2), .done(done2), .err_count(err2), .first_err_addr(first2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, RD_LAT=1: combinational read; bit 3 stuck-at-0 at 17 and 200.
  always @(posedge clk) if (wren) mem[address] <= data;
  always_comb begin
    q = mem[address];
    if (inj && (address == 8'd17 || address == 8'd200)) q[3] = 1'b0;
  end

  // RAM model, RD_LAT=2: one output register; bit 0 flipped at address 5.
  always @(posedge clk) begin
    if (wren2) mem2[address2] <= data2;
    q2 <= q2_c;
  end
  always_comb begin
    q2_c = mem2[address2];
    if (inj2 && address2 == 4'd5) q2_c[0] = ~q2_c[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_big(input logic [1:0] m, input logic v, input logic [7:0] fv,
                         input int exp_err, input int exp_first, input string tag);
    wr_t w;
    res_t r;
    int dc;
    int nw;
    for (int i = 0; i < DP; i++) begin
      w.a = 8'(i);
      if (m == 2'b01)      w.d = fv;
      else if (m == 2'b10) w.d = 8'(DP - 1 - i);
      else                 w.d = 8'(i);
      wq.push_back(w);
    end
    r.err = exp_err; r.first = exp_first; r.dcyc = v ? (2 * DP + RL) : DP;
    rq.push_back(r);
    dc = -1; nw = 0;
    @(negedge clk);
    mode = m; verify = v; fill_value = fv; start = 1'b1; reset_n = 1'b1;
    @(posedge clk);  // E0
    for (int c = 0; c < 3 * DP + 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mode = ~m; verify = ~v; fill_value = ~fv;  // must be ignored now
      end
      if (wren) begin
        nw++;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk({tag, "_addr"}, 32'(address), 32'(w.a));
          chk({tag, "_data"}, 32'(data), 32'(w.d));
        end
      end
      if (done) begin
        dc = c;
        break;
      end
    end
    r = rq.pop_front();
    chk({tag, "_done_cycle"}, dc, r.dcyc);
    chk({tag, "_nwrites"}, nw, DP);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), r.err);
    chk({tag, "_first_err"}, 32'(first_err_addr), r.first);
    wq.delete();
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_fall"}, 32'(done), 32'd0);
    chk({tag, "_err_held"}, 32'(err_count), r.err);
    chk({tag, "_first_held"}, 32'(first_err_addr), r.first);
  endtask

  task automatic run_small(input logic [1:0] m, input logic v,
                           input int exp_err, input int exp_first, input string tag);
    wr_t w;
    res_t r;
    int dc;
    int nw;
    for (int i = 0; i < DP2; i++) begin
      w.a = 8'(i);
      w.d = (m == 2'b10) ? 8'(DP2 - 1 - i) : 8'(i);
      wq.push_back(w);
    end
    r.err = exp_err; r.first = exp_first; r.dcyc = v ? (2 * DP2 + RL2) : DP2;
    rq.push_back(r);
    dc = -1; nw = 0;
    @(negedge clk);
    mode2 = m; verify2 = v; fill2 = 8'h3C; start2 = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 3 * DP2 + 8; c++) begin
      @(negedge clk);
      if (wren2) begin
        nw++;
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk({tag, "_addr"}, 32'(address2), 32'(w.a));
          chk({tag, "_data"}, 32'(data2), 32'(w.d));
        end
      end
      if (done2) begin
        dc = c;
        break;
      end
    end
    r = rq.pop_front();
    chk({tag, "_done_cycle"}, dc, r.dcyc);
    chk({tag, "_nwrites"}, nw, DP2);
    chk({tag, "_err_count"}, 32'(err2), r.err);
    chk({tag, "_first_err"}, 32'(first2), r.first);
    wq.delete();
    start2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_fall"}, 32'(done2), 32'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    start = 1'b0; mode = 2'b00; verify = 1'b0; fill_value = 8'h00; inj = 1'b0;
    start2 = 1'b0; mode2 = 2'b00; verify2 = 1'b0; fill2 = 8'h00; inj2 = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state of both instances
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_first", 32'(first_err_addr), 32'd0);
    chk("rst2_wren", 32'(wren2), 32'd0);
    chk("rst2_done", 32'(done2), 32'd0);
    chk("rst2_err", 32'(err2), 32'd0);
    reset_n = 1'b1;

    // Identity fill, no verify
    run_big(2'b00, 1'b0, 8'h00, 0, 0, "ident");
    for (int i = 0; i < DP; i++) chk($sformatf("ident_mem%0d", i), 32'(mem[i]), i);

    // Constant fill with verify on an ideal RAM
    run_big(2'b01, 1'b1, 8'hA5, 0, 0, "const");
    for (int i = 0; i < DP; i++) chk($sformatf("const_mem%0d", i), 32'(mem[i]), 32'hA5);

    // Stuck-at-0 on bit 3 at 17 and 200; 5A has bit 3 set so the fault shows
    inj = 1'b1;
    run_big(2'b01, 1'b1, 8'h5A, 2, 17, "stuck");
    inj = 1'b0;

    // Abort while address 100 is being written
    @(negedge clk);
    mode = 2'b00; verify = 1'b0; start = 1'b1;
    @(posedge clk);
    found = 0;
    for (int c = 0; c < DP; c++) begin
      @(negedge clk);
      if (wren && address == 8'd100) begin
        found = 1;
        break;
      end
    end
    chk("abort_reach", found, 1);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wren", 32'(wren), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_done_hold", 32'(done), 32'd0);
      chk("abort_wren_hold", 32'(wren), 32'd0);
    end
    chk("abort_mem99", 32'(mem[99]), 32'd99);
    chk("abort_mem100", 32'(mem[100]), 32'd100);
    chk("abort_mem101", 32'(mem[101]), 32'h5A);
    chk("abort_mem255", 32'(mem[255]), 32'h5A);

    // A fresh start rewrites from address 0
    run_big(2'b00, 1'b0, 8'h00, 0, 0, "restart");
    chk("restart_mem101", 32'(mem[101]), 32'd101);

    // Reset pulsed mid-READ, start left high
    inj = 1'b1;
    @(negedge clk);
    mode = 2'b01; verify = 1'b1; fill_value = 8'h5A; start = 1'b1;
    found = 0;
    for (int c = 0; c < 3 * DP; c++) begin
      @(negedge clk);
      if (busy && !wren && address == 8'd100) begin
        found = 1;
        break;
      end
    end
    chk("midrd_reach", found, 1);
    chk("midrd_partial_err", 32'(err_count), 32'd1);
    chk("midrd_partial_first", 32'(first_err_addr), 32'd17);
    #2 reset_n = 1'b0;
    #1;
    chk("midrd_rst_address", 32'(address), 32'd0);
    chk("midrd_rst_data", 32'(data), 32'd0);
    chk("midrd_rst_wren", 32'(wren), 32'd0);
    chk("midrd_rst_busy", 32'(busy), 32'd0);
    chk("midrd_rst_done", 32'(done), 32'd0);
    chk("midrd_rst_err", 32'(err_count), 32'd0);
    chk("midrd_rst_first", 32'(first_err_addr), 32'd0);
    inj = 1'b0;
    @(negedge clk);
    chk("midrd_rst_busy_hold", 32'(busy), 32'd0);
    run_big(2'b01, 1'b1, 8'h5A, 0, 0, "post_rst");

    // Small instance: reverse with verify, RD_LAT=2
    run_small(2'b10, 1'b1, 0, 0, "rev");
    for (int i = 0; i < DP2; i++) chk($sformatf("rev_mem%0d", i), 32'(mem2[i]), 32'(DP2 - 1 - i));
    inj2 = 1'b1;
    run_small(2'b10, 1'b1, 1, 5, "rev_flt");
    inj2 = 1'b0;
    // Reserved mode behaves as identity
    run_small(2'b11, 1'b1, 0, 0, "rsvd");
    for (int i = 0; i < DP2; i++) chk($sformatf("rsvd_mem%0d", i), 32'(mem2[i]), i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fill_engine.md
# mem_fill_engine

Parametrised memory initialiser and checker for the on-chip S-array RAM of the decryption datapath. On a start/done handshake it sweeps addresses 0..DEPTH-1 writing a selectable pattern (identity, constant, reverse), then optionally reads every location back and counts mismatches. It replaces the fixed 256-entry identity-fill loop ahead of the key-scheduling stage, and doubles as a built-in RAM self-test.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width; the pattern is truncated to DATA_W LSBs
- DEPTH, 256, number of locations swept; 2 ≤ DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, RAM read latency in cycles (1..4)

- clk  in  1  clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level request; held high for the whole run
- mode  in  2  00 identity (data=addr), 01 constant (fill_value), 10 reverse (DEPTH-1-addr), 11 reserved (treated as 00)
- verify  in  1  1 = perform read-back pass after write pass
- fill_value  in  DATA_W  constant for mode 01
- q  in  DATA_W  RAM read data
- address  out  ADDR_W  RAM address
- data  out  DATA_W  RAM write data
- wren  out  1  RAM write enable
- busy  out  1  high in WRITE, READ, DRAIN
- done  out  1  high in DONE
- err_count  out  ADDR_W+1  mismatches in the last verify pass, saturating
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Reset (async, reset_n=0): state IDLE; address, data, wren, busy, done, err_count, first_err_addr all 0; compare pipeline cleared.
- IDLE: mode, verify, fill_value latched on the edge where start=1 is sampled; err_count and first_err_addr cleared on that edge; next WRITE. Inputs ignored after latching.
- WRITE: one write per cycle, address 0..DEPTH-1, data=pattern(address), wren=1. After address DEPTH-1: verify=1 → READ, else → DONE.
- READ: wren=0, address 0..DEPTH-1 one per cycle. Expected value and address travel through an RD_LAT-deep shift register alongside the read.
- DRAIN: RD_LAT cycles, no new addresses; pipeline completes outstanding compares; then DONE.
- Compare: on each edge where a pipeline entry becomes due, q ≠ expected → err_count += 1 (holds at 2^(ADDR_W+1)-1); first_err_addr is captured only on the first mismatch of the run.
- DONE: wren=0, done=1, results held stable; when start=0 → IDLE (done falls next edge). Results persist in IDLE until the next start.
- Abort: start=0 sampled in WRITE, READ or DRAIN → IDLE next edge, wren=0, done never asserted, pipeline flushed, err_count/first_err_addr hold partial values.
- Address counter is ADDR_W+1 wide internally; no wrap when DEPTH=2^ADDR_W.

## Timing
- Edge E0 samples start=1 in IDLE. Cycle after E0: address=0, wren=1.
- Write of address n is presented in cycle E0+n (n=0..DEPTH-1); the RAM captures it on edge E0+n+1.
- No verify: edge E0+DEPTH → wren=0, done=1. Total DEPTH+1 edges from start to done.
- Verify: read of address n is presented in cycle E0+DEPTH+n; q is compared on edge E0+DEPTH+n+RD_LAT. done=1 after edge E0+2·DEPTH+RD_LAT, with final err_count valid in the same cycle.
- Write→read turnaround is 0 cycles; the RAM is required to be read-after-write safe across distinct addresses only.
- Abort or reset has 1-edge (reset: immediate) effect on wren.

## Test plan
- DEPTH=256, mode 00, verify=0: RAM holds S[i]=i for all 256 entries; wren high exactly 256 cycles; done high 257 edges after start; err_count=0.
- mode 01, fill_value=8'hA5, verify=1, ideal RAM model with RD_LAT=1: every location reads A5; err_count=0, first_err_addr=0; done at E0+513.
- Same, with the RAM model forcing bit 3 stuck-at-0 at addresses 17 and 200: err_count=2, first_err_addr=17.
- ADDR_W=4, DEPTH=16, RD_LAT=2, mode 10, verify=1: location n holds 15-n; err_count=0; done after edge E0+34.
- start dropped while address=100 in WRITE: wren=0 and busy=0 on the next edge; done stays 0; addresses ≥101 untouched; a fresh start rewrites from 0.
- reset_n pulsed low mid-READ: all outputs 0 immediately; after release with start=1, a complete run occurs and err_count reflects only the new run.
